// File: rtl/urv_divide_seq_pkg.sv
// Shared definitions for the RV32M iterative divider: function codes,
// writeback select, FSM state encoding and small sign helpers.
package urv_divide_seq_pkg;

    localparam logic [2:0] FUNC_DIV  = 3'b100;
    localparam logic [2:0] FUNC_DIVU = 3'b101;
    localparam logic [2:0] FUNC_REM  = 3'b110;
    localparam logic [2:0] FUNC_REMU = 3'b111;

    localparam logic [2:0] RD_SOURCE_DIVIDE = 3'b101;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ITER = 2'b01,
        DIV_FIX  = 2'b10,
        DIV_DONE = 2'b11
    } div_state_t;

    function automatic logic [31:0] f_abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] f_neg_if(input logic [31:0] v, input logic en);
        return en ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/urv_divide_seq_if.sv
// Execute-stage <-> divider handshake: operands, kill, stall and result.
interface urv_divide_seq_if;
    logic        x_start_i;
    logic [2:0]  x_fun_i;
    logic [31:0] x_rs1_i;
    logic [31:0] x_rs2_i;
    logic        x_kill_i;
    logic        x_stall_req_o;
    logic        x_busy_o;
    logic        x_done_o;
    logic [31:0] x_result_o;

    modport slave (
        input  x_start_i, x_fun_i, x_rs1_i, x_rs2_i, x_kill_i,
        output x_stall_req_o, x_busy_o, x_done_o, x_result_o
    );

    modport master (
        output x_start_i, x_fun_i, x_rs1_i, x_rs2_i, x_kill_i,
        input  x_stall_req_o, x_busy_o, x_done_o, x_result_o
    );
endinterface

// File: rtl/urv_div_step.sv
// One combinational restoring-division step on the {rem,quot} pair.
module urv_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quot,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quot
);

    logic [32:0] w_shifted;
    logic [32:0] w_trial;

    // Shift in the next dividend bit and keep the difference if no borrow.
    always_comb begin
        w_shifted = {i_rem, i_quot[31]};
        w_trial   = w_shifted - {1'b0, i_divisor};
        if (!w_trial[32]) begin
            o_rem  = w_trial[31:0];
            o_quot = {i_quot[30:0], 1'b1};
        end else begin
            o_rem  = w_shifted[31:0];
            o_quot = {i_quot[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/urv_divide_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer beside the execute stage;
// stalls the pipeline until the sign-corrected result is registered.
module urv_divide_seq
    import urv_divide_seq_pkg::*;
#(
    parameter int g_bits_per_cycle = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    urv_divide_seq_if.slave x_if
);

    localparam int         N    = 32 / g_bits_per_cycle;
    localparam logic [4:0] LAST = 5'(N - 1);

    generate
        if (g_bits_per_cycle != 1 && g_bits_per_cycle != 2 && g_bits_per_cycle != 4) begin : g_bad_param
            $error("urv_divide_seq: g_bits_per_cycle must be 1, 2 or 4");
        end
    endgenerate

    div_state_t  r_state;
    logic [4:0]  r_cnt;
    logic        r_sel_rem;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_divisor;
    logic [31:0] r_result;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_done;

    logic        w_signed;
    logic        w_accept;
    logic        w_div_zero;
    logic        w_overflow;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [31:0] w_rem  [0:g_bits_per_cycle];
    logic [31:0] w_quot [0:g_bits_per_cycle];

    assign w_signed   = ~x_if.x_fun_i[0];
    assign w_accept   = (r_state == DIV_IDLE) & x_if.x_start_i & ~x_if.x_kill_i;
    assign w_div_zero = (x_if.x_rs2_i == 32'h0000_0000);
    assign w_overflow = w_signed & (x_if.x_rs1_i == 32'h8000_0000) & (x_if.x_rs2_i == 32'hFFFF_FFFF);
    assign w_q_fix    = f_neg_if(r_quot, r_neg_q);
    assign w_r_fix    = f_neg_if(r_rem, r_neg_r);

    assign w_rem[0]  = r_rem;
    assign w_quot[0] = r_quot;

    generate
        for (genvar i = 0; i < g_bits_per_cycle; i++) begin : g_step
            urv_div_step u_step (
                .i_rem     (w_rem[i]),
                .i_quot    (w_quot[i]),
                .i_divisor (r_divisor),
                .o_rem     (w_rem[i+1]),
                .o_quot    (w_quot[i+1])
            );
        end
    endgenerate

    // Stall drops in DONE so exactly one instruction leaves execute.
    assign x_if.x_stall_req_o = ~x_if.x_kill_i &
                                (w_accept | (r_state == DIV_ITER) | (r_state == DIV_FIX));
    assign x_if.x_busy_o      = (r_state != DIV_IDLE);
    assign x_if.x_done_o      = r_done;
    assign x_if.x_result_o    = r_result;

    // Sequencer FSM with the operand, iteration and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= 5'd0;
            r_sel_rem <= 1'b0;
            r_rem     <= 32'h0000_0000;
            r_quot    <= 32'h0000_0000;
            r_divisor <= 32'h0000_0000;
            r_result  <= 32'h0000_0000;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (x_if.x_kill_i) begin
                r_state <= DIV_IDLE;
            end else begin
                case (r_state)
                    DIV_IDLE: begin
                        if (x_if.x_start_i) begin
                            r_sel_rem <= x_if.x_fun_i[1];
                            r_divisor <= f_abs_if(x_if.x_rs2_i, w_signed);
                            r_neg_q   <= w_signed & (x_if.x_rs1_i[31] ^ x_if.x_rs2_i[31]);
                            r_neg_r   <= w_signed & x_if.x_rs1_i[31];
                            r_cnt     <= 5'd0;
                            // Architectural corner cases bypass the iteration.
                            if (w_div_zero) begin
                                r_quot   <= 32'hFFFF_FFFF;
                                r_rem    <= x_if.x_rs1_i;
                                r_result <= x_if.x_fun_i[1] ? x_if.x_rs1_i : 32'hFFFF_FFFF;
                                r_done   <= 1'b1;
                                r_state  <= DIV_DONE;
                            end else if (w_overflow) begin
                                r_quot   <= 32'h8000_0000;
                                r_rem    <= 32'h0000_0000;
                                r_result <= x_if.x_fun_i[1] ? 32'h0000_0000 : 32'h8000_0000;
                                r_done   <= 1'b1;
                                r_state  <= DIV_DONE;
                            end else begin
                                r_quot  <= f_abs_if(x_if.x_rs1_i, w_signed);
                                r_rem   <= 32'h0000_0000;
                                r_state <= DIV_ITER;
                            end
                        end else begin
                            r_state <= DIV_IDLE;
                        end
                    end
                    DIV_ITER: begin
                        r_rem  <= w_rem[g_bits_per_cycle];
                        r_quot <= w_quot[g_bits_per_cycle];
                        r_cnt  <= r_cnt + 5'd1;
                        if (r_cnt == LAST) begin
                            r_state <= DIV_FIX;
                        end else begin
                            r_state <= DIV_ITER;
                        end
                    end
                    DIV_FIX: begin
                        r_result <= r_sel_rem ? w_r_fix : w_q_fix;
                        r_done   <= 1'b1;
                        r_state  <= DIV_DONE;
                    end
                    DIV_DONE: begin
                        r_state <= DIV_IDLE;
                    end
                    default: begin
                        r_state <= DIV_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_urv_divide_seq.sv
// Bench for urv_divide_seq: one instance at 1 bit/cycle, one at 4 bits/cycle.
module tb_urv_divide_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        st [2];
    logic [2:0]  fn [2];
    logic [31:0] a  [2];
    logic [31:0] b  [2];
    logic        kl [2];
    logic        o_st [2];
    logic        o_busy [2];
    logic        o_done [2];
    logic [31:0] o_res [2];

    urv_divide_seq_if u_if0 ();
    urv_divide_seq_if u_if1 ();

    assign u_if0.x_start_i = st[0];
    assign u_if0.x_fun_i   = fn[0];
    assign u_if0.x_rs1_i   = a[0];
    assign u_if0.x_rs2_i   = b[0];
    assign u_if0.x_kill_i  = kl[0];
    assign u_if1.x_start_i = st[1];
    assign u_if1.x_fun_i   = fn[1];
    assign u_if1.x_rs1_i   = a[1];
    assign u_if1.x_rs2_i   = b[1];
    assign u_if1.x_kill_i  = kl[1];
    assign o_st[0]   = u_if0.x_stall_req_o;
    assign o_busy[0] = u_if0.x_busy_o;
    assign o_done[0] = u_if0.x_done_o;
    assign o_res[0]  = u_if0.x_result_o;
    assign o_st[1]   = u_if1.x_stall_req_o;
    assign o_busy[1] = u_if1.x_busy_o;
    assign o_done[1] = u_if1.x_done_o;
    assign o_res[1]  = u_if1.x_result_o;

    urv_divide_seq #(.g_bits_per_cycle(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .x_if(u_if0));
    urv_divide_seq #(.g_bits_per_cycle(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .x_if(u_if1));

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h want %h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    // Reference RV32M semantics.
    function automatic logic ref_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return (y == 32'h0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        logic [31:0] q, r;
        if (y == 32'h0) begin
            q = 32'hFFFF_FFFF; r = x;
        end else if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'h0;
        end else if (!f[0]) begin
            sx = x; sy = y;
            q = sx / sy; r = sx % sy;
        end else begin
            q = x / y; r = x % y;
        end
        return f[1] ? r : q;
    endfunction

    // Model: cycles left before DONE, whether this cycle is DONE, visible result.
    int          m_left [2];
    logic        m_done [2];
    logic [31:0] m_res  [2];
    logic [31:0] m_out  [2];
    int          nn     [2];
    initial begin nn[0] = 32; nn[1] = 8; end

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_left[d] <= 0; m_done[d] <= 1'b0; m_out[d] <= 32'h0;
            end else if (m_done[d]) begin
                m_done[d] <= 1'b0;
            end else if (m_left[d] > 0) begin
                if (kl[d]) m_left[d] <= 0;
                else begin
                    m_left[d] <= m_left[d] - 1;
                    if (m_left[d] == 1) begin m_done[d] <= 1'b1; m_out[d] <= m_res[d]; end
                end
            end else if (st[d] && !kl[d]) begin
                m_res[d] <= ref_div(fn[d], a[d], b[d]);
                if (ref_special(fn[d], a[d], b[d])) begin
                    m_done[d] <= 1'b1; m_out[d] <= ref_div(fn[d], a[d], b[d]);
                end else begin
                    m_left[d] <= nn[d] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic busy_e, stall_e;
                busy_e  = (m_left[d] > 0) || m_done[d];
                stall_e = !kl[d] && ((m_left[d] > 0) || (!busy_e && st[d]));
                chk("cyc_busy",  d, {31'h0, o_busy[d]}, {31'h0, busy_e});
                chk("cyc_done",  d, {31'h0, o_done[d]}, {31'h0, m_done[d]});
                chk("cyc_stall", d, {31'h0, o_st[d]},   {31'h0, stall_e});
                chk("cyc_result", d, o_res[d], m_out[d]);
            end
        end
    end

    task automatic run_op(input int d, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int exp_lat, input int exp_stalls);
        int cyc, nst;
        logic got;
        st[d] = 1'b1; fn[d] = f; a[d] = x; b[d] = y;
        #1;
        chk("start_stall", d, {31'h0, o_st[d]}, 32'h1);
        cyc = 0; nst = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (o_done[d]) got = 1'b1;
            else if (o_st[d]) nst++;
        end
        chk("done_seen", d, {31'h0, got}, 32'h1);
        chk("result", d, o_res[d], exp);
        chk("latency", d, cyc, exp_lat);
        chk("stalls_after_start", d, nst, exp_stalls);
        @(posedge clk); #1;
        st[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; fn[d] = 3'b100; a[d] = 32'h0; b[d] = 32'h0; kl[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy",   d, {31'h0, o_busy[d]}, 32'h0);
            chk("rst_done",   d, {31'h0, o_done[d]}, 32'h0);
            chk("rst_stall",  d, {31'h0, o_st[d]},   32'h0);
            chk("rst_result", d, o_res[d], 32'h0);
        end

        run_op(0, 3'b100, 32'd100, 32'd7, 32'd14, 34, 33);
        run_op(0, 3'b110, 32'd100, 32'd7, 32'd2, 34, 33);
        run_op(0, 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 33);
        run_op(0, 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 33);
        run_op(0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 33);
        run_op(0, 3'b111, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 34, 33);

        // Flush in the tenth ITER cycle.
        st[0] = 1'b1; fn[0] = 3'b100; a[0] = 32'd1000; b[0] = 32'd3;
        for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
        chk("kill_pre_busy", 0, {31'h0, o_busy[0]}, 32'h1);
        kl[0] = 1'b1;
        #1;
        chk("kill_stall", 0, {31'h0, o_st[0]}, 32'h0);
        @(posedge clk); #1;
        kl[0] = 1'b0; st[0] = 1'b0;
        #1;
        chk("kill_busy",   0, {31'h0, o_busy[0]}, 32'h0);
        chk("kill_done",   0, {31'h0, o_done[0]}, 32'h0);
        chk("kill_result", 0, o_res[0], 32'h0000_000F);
        @(posedge clk); #1;
        run_op(0, 3'b100, 32'd9, 32'd3, 32'd3, 34, 33);

        run_op(0, 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op(0, 3'b110, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);

        run_op(0, 3'b100, 32'd50, 32'd5, 32'd10, 34, 33);
        run_op(0, 3'b100, 32'd81, 32'd9, 32'd9, 34, 33);

        // Asynchronous reset in the middle of an iteration.
        st[0] = 1'b1; fn[0] = 3'b100; a[0] = 32'd100; b[0] = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; st[0] = 1'b0;
        #1;
        chk("amid_rst_busy",   0, {31'h0, o_busy[0]}, 32'h0);
        chk("amid_rst_done",   0, {31'h0, o_done[0]}, 32'h0);
        chk("amid_rst_stall",  0, {31'h0, o_st[0]},   32'h0);
        chk("amid_rst_result", 0, o_res[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1, 3'b100, 32'd100, 32'd7, 32'd14, 10, 9);
        run_op(1, 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 10, 9);
        run_op(1, 3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 10, 9);
        run_op(1, 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/urv_divide_seq.md
Name: urv_divide_seq

Overview:
- Iterative sequencer for RV32M DIV/DIVU/REM/REMU, sitting beside the execute stage.
- Decode flags these ops today and hands rs1/rs2/fun to execute; this block takes them from execute.
- It runs a restoring-division datapath over multiple cycles and holds the pipeline through its stall request until the result is ready.
- It owns the FSM, the iteration counter, the operand/remainder/quotient registers and the sign fix-up.

Parameters:
- g_bits_per_cycle, 1: quotient bits resolved per cycle. Legal values are 1, 2 and 4; any other value is a synthesis error. Iteration count N = 32 / g_bits_per_cycle.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- x_start_i  in  1  valid divide op present in execute (valid, not killed, fun[2]=1, funct7[0]=1)
- x_fun_i  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- x_rs1_i  in  32  dividend
- x_rs2_i  in  32  divisor
- x_kill_i  in  1  flush of execute stage
- x_stall_req_o  out  1  hold pipeline
- x_busy_o  out  1  FSM not IDLE
- x_done_o  out  1  result valid this cycle
- x_result_o  out  32  quotient or remainder

Behaviour:
- States: IDLE, ITER, FIX, DONE. Encoded 2-bit.
- Reset: state=IDLE, counter=0, x_done_o=0, x_busy_o=0, x_result_o=0. Datapath registers also clear to 0.
- IDLE + x_start_i + !x_kill_i: latch the op.
  - Latched: fun; |rs1| and |rs2| (abs only when signed); neg_q = signed & (rs1[31]^rs2[31]); neg_r = signed & rs1[31].
  - Remainder accumulator cleared.
  - Divisor == 0: set q=0xFFFFFFFF, r=rs1, go to DONE.
  - Signed, rs1==0x80000000 and rs2==0xFFFFFFFF: set q=0x80000000, r=0, go to DONE.
  - Otherwise: go to ITER with counter=0.
- ITER:
  - Each cycle applies g_bits_per_cycle restoring steps: shift the {rem,quot} pair left 1, trial-subtract the divisor, keep the result if non-negative and set the quotient LSB.
  - Counter increments. At counter==N-1, go to FIX.
- FIX (one cycle):
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Select the quotient for fun[1]=0 and the remainder for fun[1]=1, register it into x_result_o, go to DONE.
  - Special-case results from IDLE are registered into x_result_o directly on the IDLE->DONE transition.
- DONE (one cycle): x_done_o=1 and x_result_o is valid. Always return to IDLE. x_start_i is ignored, because the same instruction is still presented.
- x_stall_req_o is combinational:
  - (IDLE & x_start_i & !x_kill_i) | ITER | FIX.
  - Deasserted in DONE, so the pipeline advances exactly one instruction.
  - Forced 0 whenever x_kill_i=1.
- x_busy_o = (state != IDLE).
- Latency, start sampled at T:
  - Normal op: ITER T+1..T+N, FIX T+N+1, DONE T+N+2. With N=32: 34 cycles, and 33 stall cycles seen by the pipeline.
  - Special cases: DONE at T+1.
- x_kill_i in any state: next state IDLE, no x_done_o pulse, x_result_o holds its previous value.
- Back-to-back divides: a new start is accepted in the IDLE cycle immediately after DONE. No dead cycle is required beyond that.
- Reset mid-operation: immediate IDLE, outputs go to their reset values.
- All arithmetic is unsigned 33-bit for the trial subtract. Remainder width is 32 and the carry is discarded.

Decomposition:
- urv_defs gains:
  - FUNC_DIV/DIVU/REM/REMU constants (3'b100..3'b111).
  - A RD_SOURCE_DIVIDE select for the writeback mux.
  - DIV_IDLE/ITER/FIX/DONE state encodings.
- Sub-module urv_div_step: purely combinational single restoring step.
  - Inputs: rem[31:0], quot[31:0], divisor[31:0].
  - Outputs: rem', quot'.
  - Chained g_bits_per_cycle times inside urv_divide_seq via a generate loop.

Test Plan:
- DIV 100/7: result 14 at DONE, x_stall_req_o high for exactly 33 cycles (g_bits_per_cycle=1); REM same operands -> 2.
- REM -100/7 -> 0xFFFFFFFE (-2); DIV -100/7 -> 0xFFFFFFF2 (-14); DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; REMU 0xFFFFFFFF/0x10 -> 0xF.
- DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each DONE at T+1 with a single stall cycle.
- Start DIV 1000/3, assert x_kill_i at ITER cycle 10 -> IDLE next cycle, no done pulse, stall drops that cycle; a new DIV 9/3 then returns 3.
- Two consecutive DIVs 50/5 then 81/9: results 10 and 9, second accepted the cycle after the first DONE, no spurious done.
- rst_i pulsed mid-ITER -> all outputs are 0 in the same cycle (async), FSM IDLE; g_bits_per_cycle=4 rerun of 100/7 -> 14 with DONE at T+10.
